// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   state_t        : arbiter state encoding (IDLE / OCUPADO / ESPERA)
//   N_REQ, SEL_W   : requester count and select width
//   MAX_TICKS      : grant-cycle limit per owner (only used with ARB_TIMEOUT_EN)
//   idx_to_onehot / onehot_to_idx : grant vector <-> owner index helpers
package arbitro_pkg;

    localparam int N_REQ     = 4;
    localparam int SEL_W     = 2;
    localparam int MAX_TICKS = 8;
    localparam int TICK_W    = $clog2(MAX_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OCUPADO = 2'd1,
        ESPERA  = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbitro_multiplexor_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   i_Req    : level request per requester
//   o_Grant  : one-hot grant, zero when no owner
//   o_Sel    : mux select, index of current/last owner
//   o_Valido : an owner currently holds the mux
// master = requester side, slave = arbiter side.
interface arbitro_multiplexor_if;
    import arbitro_pkg::*;

    logic [N_REQ-1:0] i_Req;
    logic [N_REQ-1:0] o_Grant;
    logic [SEL_W-1:0] o_Sel;
    logic             o_Valido;

    modport master (output i_Req, input o_Grant, input o_Sel, input o_Valido);
    modport slave  (input i_Req, output o_Grant, output o_Sel, output o_Valido);
endinterface

// File: rtl/selector_rr.sv
// Combinational round-robin priority pick.
//   req    : request vector
//   ptr    : index of the last winner (lowest priority this round)
//   hit    : at least one request present
//   winner : first requester found scanning ptr+1, ptr+2, ... modulo N_REQ
module selector_rr
    import arbitro_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             hit,
    output logic [SEL_W-1:0] winner
);

    logic [SEL_W-1:0] idx;

    // Scan from the far end back to ptr+1 so the nearest candidate is written last and wins.
    always_comb begin
        hit    = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                hit    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_multiplexor.sv
// Round-robin arbiter sharing one 4:1 multiplexor among four requesters.
// Grants are held while the owner keeps requesting; a one-cycle gap separates owners.
// o_Sel feeds the mux select and keeps the last owner during gaps.
//   i_Clk   : clock, rising edge
//   i_Rst_n : asynchronous active-low reset
//   bus     : arbitro_multiplexor_if.slave (i_Req in; o_Grant, o_Sel, o_Valido out)
// Optional build macro ARB_TIMEOUT_EN: revoke a grant after MAX_TICKS owner cycles.
//
// state   | meaning
// IDLE    | no owner, arbitrating every cycle
// OCUPADO | owner granted, held while its request stays high
// ESPERA  | one-cycle turnaround, outputs invalid, arbitrating
module arbitro_multiplexor
    import arbitro_pkg::*;
(
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    arbitro_multiplexor_if.slave  bus
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valido_q, valido_d;

    logic             hit;
    logic [SEL_W-1:0] winner;
    logic             timeout;

    selector_rr u_selector_rr (
        .req    (bus.i_Req),
        .ptr    (ptr_q),
        .hit    (hit),
        .winner (winner)
    );

`ifdef ARB_TIMEOUT_EN
    logic [TICK_W-1:0] tick_q, tick_d;

    // Counts completed owner cycles; held at zero outside OCUPADO so entry starts clean.
    always_comb begin
        tick_d = '0;
        if (state_q == OCUPADO) tick_d = tick_q + TICK_W'(1);
    end

    assign timeout = (state_q == OCUPADO) && (tick_q == TICK_W'(MAX_TICKS - 1));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) tick_q <= '0;
        else          tick_q <= tick_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        valido_d = valido_q;
        case (state_q)
            IDLE, ESPERA: begin
                if (hit) begin
                    state_d  = OCUPADO;
                    ptr_d    = winner;
                    sel_d    = winner;
                    grant_d  = idx_to_onehot(winner);
                    valido_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    valido_d = 1'b0;
                end
            end
            OCUPADO: begin
                // Request drop and timeout together still give a single turnaround.
                if (!bus.i_Req[sel_q] || timeout) begin
                    state_d  = ESPERA;
                    grant_d  = '0;
                    valido_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                valido_d = 1'b0;
            end
        endcase
    end

    // ptr resets to the last index so requester 0 has top priority first.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= SEL_W'(N_REQ - 1);
            grant_q  <= '0;
            sel_q    <= '0;
            valido_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            valido_q <= valido_d;
        end
    end

    assign bus.o_Grant  = grant_q;
    assign bus.o_Sel    = sel_q;
    assign bus.o_Valido = valido_q;

endmodule

// File: tb/tb_arbitro_multiplexor.sv
module tb_arbitro_multiplexor;
    import arbitro_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arbitro_multiplexor_if bus ();

    arbitro_multiplexor dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    // Reference model: current owner (-1 = none), last winner, visible select, cycles held.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_held;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_sel   = 0;
        m_held  = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        if (m_owner >= 0) begin
            m_held++;
            if (!r[m_owner] || (TMO && m_held >= MAX_TICKS)) m_owner = -1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (r[c]) begin
                    m_owner = c;
                    m_ptr   = c;
                    m_sel   = c;
                    m_held  = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_grant"}, int'(bus.o_Grant), (m_owner >= 0) ? (1 << m_owner) : 0);
        chk({tag, "_sel"},   int'(bus.o_Sel),   m_sel);
        chk({tag, "_valid"}, int'(bus.o_Valido), (m_owner >= 0) ? 1 : 0);
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic v);
        vec_t e;
        e.req = r; e.grant = g; e.sel = s; e.valid = v;
        vecs.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_Req = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_grant", int'(bus.o_Grant), 0);
        chk("rst_sel",   int'(bus.o_Sel),   0);
        chk("rst_valid", int'(bus.o_Valido), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rq;
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        bus.i_Req = '0;
        #2;

        // Fairness with all requesting, each owner dropping after 2 granted cycles.
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1110, 4'b0000, 2'd0, 1'b0);
        add(4'b1111, 4'b0010, 2'd1, 1'b1);
        add(4'b1111, 4'b0010, 2'd1, 1'b1);
        add(4'b1101, 4'b0000, 2'd1, 1'b0);
        add(4'b1111, 4'b0100, 2'd2, 1'b1);
        add(4'b1111, 4'b0100, 2'd2, 1'b1);
        add(4'b1011, 4'b0000, 2'd2, 1'b0);
        add(4'b1111, 4'b1000, 2'd3, 1'b1);
        add(4'b1111, 4'b1000, 2'd3, 1'b1);
        add(4'b0111, 4'b0000, 2'd3, 1'b0);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        // No preemption: owner 1 keeps the mux while 0 waits.
        add(4'b0010, 4'b0010, 2'd1, 1'b1);
        add(4'b0011, 4'b0010, 2'd1, 1'b1);
        add(4'b0011, 4'b0010, 2'd1, 1'b1);
        add(4'b0001, 4'b0000, 2'd1, 1'b0);
        add(4'b0001, 4'b0001, 2'd0, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        // Single request held 5 cycles, then sole requester re-asserting.
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);

        do_reset();
        foreach (vecs[i]) begin
            bus.i_Req = vecs[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_grant", i), int'(bus.o_Grant), int'(vecs[i].grant));
            chk($sformatf("vec%0d_sel", i),   int'(bus.o_Sel),   int'(vecs[i].sel));
            chk($sformatf("vec%0d_valid", i), int'(bus.o_Valido), int'(vecs[i].valid));
        end

        // Asynchronous reset in the middle of owner 2's grant.
        do_reset();
        bus.i_Req = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_arst_sel",   int'(bus.o_Sel),   2);
        chk("pre_arst_valid", int'(bus.o_Valido), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", int'(bus.o_Grant), 0);
        chk("arst_sel",   int'(bus.o_Sel),   0);
        chk("arst_valid", int'(bus.o_Valido), 0);

        // Requesters 0 and 1 held continuously.
        do_reset();
        bus.i_Req = 4'b0011;
        for (int c = 1; c <= 20; c++) begin
            int k, eo, es, ev;
            @(posedge clk);
            #1;
            if (TMO) begin
                k = (c - 1) % (2 * (MAX_TICKS + 1));
                if (k < MAX_TICKS)                begin eo = 0;  es = 0; ev = 1; end
                else if (k == MAX_TICKS)          begin eo = -1; es = 0; ev = 0; end
                else if (k < 2 * MAX_TICKS + 1)   begin eo = 1;  es = 1; ev = 1; end
                else                              begin eo = -1; es = 1; ev = 0; end
            end else begin
                eo = 0; es = 0; ev = 1;
            end
            chk($sformatf("hold%0d_grant", c), int'(bus.o_Grant), (eo >= 0) ? (1 << eo) : 0);
            chk($sformatf("hold%0d_sel", c),   int'(bus.o_Sel),   es);
            chk($sformatf("hold%0d_valid", c), int'(bus.o_Valido), ev);
        end

        // Random traffic against the reference model.
        do_reset();
        rq = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            end
            bus.i_Req = rq;
            @(posedge clk);
            model_step(rq);
            #1;
            chk_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
